// File: rtl/brief_frame_seq_pkg.sv
// -----------------------------------------------------------------------------
// brief_seq_pkg
// Shared types and helpers for the BRIEF frame sequencer.
//   seq_state_t : sequencer state (S_IDLE, S_FILL, S_WORK)
//   COOR_W      : width of the window-centre coordinate outputs
//   ring_inc    : increment that wraps from modulus-1 back to 0
// -----------------------------------------------------------------------------
package brief_seq_pkg;

    localparam int COOR_W = 10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_WORK = 2'd2
    } seq_state_t;

    // Ring increment used by the SRAM address counters; anything at or past
    // the last slot goes back to slot 0 so a bad load value self-recovers.
    function automatic logic [31:0] ring_inc(input logic [31:0] value,
                                             input logic [31:0] modulus);
        if (value >= modulus - 32'd1) begin
            return 32'd0;
        end
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/brief_frame_seq_if.sv
// -----------------------------------------------------------------------------
// brief_frame_seq_if
// Line-buffer SRAM control bus plus the window-centre coordinate stream that
// the frame sequencer drives towards the SRAM bank and the BRIEF unit.
//   o_lb_wen_n   : shared port-A write enable, 0 = write
//   o_lb_addr_a  : port-A (write) address
//   o_lb_addr_b  : port-B (read) address
//   o_coor_x/y   : window-centre coordinate
//   o_coor_valid : coordinate qualifier
// Modports: master (sequencer side, drives everything), slave (consumers).
// -----------------------------------------------------------------------------
interface brief_frame_seq_if #(
    parameter int ADDR_W = 10
);

    logic                              o_lb_wen_n;
    logic [ADDR_W-1:0]                 o_lb_addr_a;
    logic [ADDR_W-1:0]                 o_lb_addr_b;
    logic [brief_seq_pkg::COOR_W-1:0]  o_coor_x;
    logic [brief_seq_pkg::COOR_W-1:0]  o_coor_y;
    logic                              o_coor_valid;

    modport master (
        output o_lb_wen_n,
        output o_lb_addr_a,
        output o_lb_addr_b,
        output o_coor_x,
        output o_coor_y,
        output o_coor_valid
    );

    modport slave (
        input o_lb_wen_n,
        input o_lb_addr_a,
        input o_lb_addr_b,
        input o_coor_x,
        input o_coor_y,
        input o_coor_valid
    );

endinterface

// File: rtl/brief_frame_seq_ring_addr.sv
// -----------------------------------------------------------------------------
// brief_ring_addr
// Loadable modulo-WIDTH counter used for the line-buffer ring addresses.
//   i_clk, i_rst  : clock, synchronous active-high reset (q -> 0)
//   i_enable      : advance by one, wrapping WIDTH-1 -> 0
//   i_load        : load i_load_value (takes priority over i_enable)
//   i_load_value  : value to load
//   o_q           : current address
// -----------------------------------------------------------------------------
module brief_ring_addr
    import brief_seq_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_value,
    output logic [ADDR_W-1:0] o_q
);

    logic [ADDR_W-1:0] r_q;

    // Address register: a load restarts the ring at a new phase, otherwise the
    // address walks round the ring one slot per enabled cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_value;
        end else if (i_enable) begin
            r_q <= ADDR_W'(ring_inc(32'(r_q), 32'(WIDTH)));
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/brief_frame_seq.sv
// -----------------------------------------------------------------------------
// brief_frame_seq
// Frame sequencer for the BRIEF line-buffer datapath. Tracks frame start/end,
// counts the line-buffer fill period, drives the ring addresses and shared
// write enable of the 30 line-buffer SRAMs, and emits the window-centre
// coordinate stream for the BRIEF unit.
//   i_clk          : clock
//   i_rst          : synchronous reset, active-high
//   i_pixel_valid  : advance enable; all state moves only when 1
//   i_start        : first pixel of a frame, qualified by i_pixel_valid
//   lb_if (master) : SRAM write enable / addresses and coordinate stream
//   o_start        : frame-start pulse (combinational)
//   o_end          : frame-end pulse (combinational)
//   o_busy         : sequencer not idle
//   o_stall_cnt    : busy cycles without a valid pixel (20 bit, saturating)
// Optional feature macro: BRIEF_SEQ_STALL_CNT_EN adds o_stall_cnt and its
// counter; without it neither the port nor the logic exists.
// -----------------------------------------------------------------------------
module brief_frame_seq
    import brief_seq_pkg::*;
#(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int FILL_CYCLES = 9612,
    parameter int RD_LEAD     = 32,
    parameter int ADDR_W      = 10
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_pixel_valid,
    input  logic               i_start,
    brief_frame_seq_if.master  lb_if,
    output logic               o_start,
    output logic               o_end,
    output logic               o_busy
`ifdef BRIEF_SEQ_STALL_CNT_EN
    ,
    output logic [19:0]        o_stall_cnt
`endif
);

    localparam int CNT_W = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES + 1) : 1;

    // The write port trails the read port by RD_LEAD slots around the ring,
    // so a frame starts with the write address RD_LEAD behind zero.
    localparam int LOAD_A = (WIDTH - RD_LEAD) % WIDTH;
    localparam int LOAD_B = 0;

    seq_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_fill_cnt, w_fill_cnt_nxt;
    logic [COOR_W-1:0] r_x, w_x_nxt;
    logic [COOR_W-1:0] r_y, w_y_nxt;
    logic              r_wen_n, w_wen_n_nxt;

    logic              w_start_evt;
    logic              w_fill_done;
    logic              w_x_last;
    logic              w_last_pix;
    logic              w_addr_en;
    logic [ADDR_W-1:0] w_addr_a;
    logic [ADDR_W-1:0] w_addr_b;

    assign w_start_evt = i_pixel_valid & i_start;
    assign w_fill_done = (r_fill_cnt == CNT_W'(FILL_CYCLES - 1));
    assign w_x_last    = (r_x == COOR_W'(WIDTH - 1));
    assign w_last_pix  = w_x_last && (r_y == COOR_W'(HEIGHT - 1));

    // Next-state and pulse logic. A start event wins over everything and
    // restarts the fill from any state; if it lands in WORK the current frame
    // is closed at the same time, so o_end fires alongside o_start. With no
    // valid pixel every next value equals the current one.
    always_comb begin
        w_state_nxt    = r_state;
        w_fill_cnt_nxt = r_fill_cnt;
        w_x_nxt        = r_x;
        w_y_nxt        = r_y;
        w_wen_n_nxt    = r_wen_n;
        o_start        = w_start_evt;
        o_end          = 1'b0;

        if (w_start_evt) begin
            w_state_nxt    = S_FILL;
            w_fill_cnt_nxt = '0;
            w_x_nxt        = '0;
            w_y_nxt        = '0;
            w_wen_n_nxt    = 1'b0;
            o_end          = (r_state == S_WORK);
        end else if (i_pixel_valid) begin
            case (r_state)
                S_IDLE: begin
                    w_wen_n_nxt = 1'b1;
                end
                S_FILL: begin
                    w_fill_cnt_nxt = r_fill_cnt + CNT_W'(1);
                    if (w_fill_done) begin
                        w_state_nxt = S_WORK;
                        w_x_nxt     = '0;
                        w_y_nxt     = '0;
                    end
                end
                S_WORK: begin
                    if (w_last_pix) begin
                        o_end       = 1'b1;
                        w_state_nxt = S_IDLE;
                        w_x_nxt     = '0;
                        w_y_nxt     = '0;
                        w_wen_n_nxt = 1'b1;
                    end else if (w_x_last) begin
                        w_x_nxt = '0;
                        w_y_nxt = r_y + COOR_W'(1);
                    end else begin
                        w_x_nxt = r_x + COOR_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_wen_n_nxt = 1'b1;
                end
            endcase
        end
    end

    // State register. Reset aborts a frame on the spot without an end pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_fill_cnt <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_wen_n    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_cnt <= w_fill_cnt_nxt;
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_wen_n    <= w_wen_n_nxt;
        end
    end

    // Both ring counters move in lock-step so the read/write spacing never
    // drifts; they only move while a frame is in flight.
    assign w_addr_en = i_pixel_valid & (r_state != S_IDLE);

    brief_ring_addr #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_addr_a (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_enable     (w_addr_en),
        .i_load       (w_start_evt),
        .i_load_value (ADDR_W'(LOAD_A)),
        .o_q          (w_addr_a)
    );

    brief_ring_addr #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_addr_b (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_enable     (w_addr_en),
        .i_load       (w_start_evt),
        .i_load_value (ADDR_W'(LOAD_B)),
        .o_q          (w_addr_b)
    );

    assign lb_if.o_lb_wen_n   = r_wen_n;
    assign lb_if.o_lb_addr_a  = w_addr_a;
    assign lb_if.o_lb_addr_b  = w_addr_b;
    assign lb_if.o_coor_x     = r_x;
    assign lb_if.o_coor_y     = r_y;
    assign lb_if.o_coor_valid = (r_state == S_WORK);
    assign o_busy             = (r_state != S_IDLE);

`ifdef BRIEF_SEQ_STALL_CNT_EN
    logic [19:0] r_stall_cnt;

    // Stall counter: counts busy cycles that had no pixel to consume,
    // saturating rather than wrapping, and restarting with each frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (w_start_evt) begin
            r_stall_cnt <= '0;
        end else if ((r_state != S_IDLE) && !i_pixel_valid && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 20'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
